// File: rtl/intbus_arbiter.sv
// intbus_arbiter: shares one byte-lane-selected RAM port between several
// 8-bit internal bus masters.
//   clk, rst_n    - clock, synchronous active-low reset
//   m_addr        - byte address per master (slice i = master i)
//   m_wrdata      - write byte per master
//   m_strobe      - request pending per master, held until acked
//   m_write       - 1 = write, 0 = read, per master
//   m_ack         - combinational grant, one-hot or zero
//   m_rddata      - registered read byte per master
//   m_rdvalid     - one-cycle read-return pulse per master
//   s_addr        - RAM word address
//   s_wrdata      - write byte replicated on all lanes
//   s_wrbytesel   - one-hot lane enable for writes, zero for reads
//   s_write       - write strobe
//   s_strobe      - access issued
//   s_rddata      - RAM read word, RD_LATENCY cycles after s_strobe
module intbus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned LANES       = 4,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ARB_MODE    = 0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]           m_addr,
  input  logic [NUM_MASTERS*8-1:0]                    m_wrdata,
  input  logic [NUM_MASTERS-1:0]                      m_strobe,
  input  logic [NUM_MASTERS-1:0]                      m_write,
  output logic [NUM_MASTERS-1:0]                      m_ack,
  output logic [NUM_MASTERS*8-1:0]                    m_rddata,
  output logic [NUM_MASTERS-1:0]                      m_rdvalid,
  output logic [ADDR_WIDTH-$clog2(LANES)-1:0]         s_addr,
  output logic [8*LANES-1:0]                          s_wrdata,
  output logic [LANES-1:0]                            s_wrbytesel,
  output logic                                        s_write,
  output logic                                        s_strobe,
  input  logic [8*LANES-1:0]                          s_rddata
);

  localparam int unsigned IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned LANE_BITS = $clog2(LANES);
  localparam int unsigned LANE_W    = (LANES > 1) ? LANE_BITS : 1;
  localparam int unsigned SADDR_W   = ADDR_WIDTH - LANE_BITS;

  logic [IDX_W-1:0]      last;
  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_wrdata;
  logic                  sel_write;
  logic [LANE_W-1:0]     sel_lane;

  // Read-return tracking: stage RD_LATENCY lines up with s_rddata
  logic [RD_LATENCY:0]   pipe_vld;
  logic [IDX_W-1:0]      pipe_idx  [0:RD_LATENCY];
  logic [LANE_W-1:0]     pipe_lane [0:RD_LATENCY];

  // Arbitration: round-robin searches from last+1, fixed searches from 0
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (ARB_MODE == 1) cand = IDX_W'(k);
      else               cand = IDX_W'((32'(last) + k + 32'd1) % NUM_MASTERS);
      if (!grant_vld && m_strobe[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (!rst_n) grant_vld = 1'b0;
  end

  always_comb begin
    m_ack = '0;
    if (grant_vld) m_ack[grant_idx] = 1'b1;
  end

  // Fields of the granted master
  assign sel_addr   = m_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wrdata = m_wrdata[32'(grant_idx)*8 +: 8];
  assign sel_write  = m_write[grant_idx];
  assign sel_lane   = LANE_W'(sel_addr) & LANE_W'(LANES - 1);

  // Slave-side registers, read-return pipeline and master read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last        <= IDX_W'(NUM_MASTERS - 1);
      s_strobe    <= 1'b0;
      s_write     <= 1'b0;
      s_wrbytesel <= '0;
      s_addr      <= '0;
      s_wrdata    <= '0;
      m_rddata    <= '0;
      m_rdvalid   <= '0;
      pipe_vld    <= '0;
      for (int unsigned i = 0; i <= RD_LATENCY; i++) begin
        pipe_idx[i]  <= '0;
        pipe_lane[i] <= '0;
      end
    end else begin
      s_strobe    <= grant_vld;
      s_write     <= grant_vld & sel_write;
      s_wrbytesel <= (grant_vld && sel_write) ? (LANES'(1) << sel_lane) : '0;
      if (grant_vld) begin
        last     <= grant_idx;
        s_addr   <= SADDR_W'(sel_addr >> LANE_BITS);
        s_wrdata <= {LANES{sel_wrdata}};
      end

      pipe_vld[0]  <= grant_vld & ~sel_write;
      pipe_idx[0]  <= grant_idx;
      pipe_lane[0] <= sel_lane;
      for (int unsigned i = 1; i <= RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
        pipe_lane[i] <= pipe_lane[i-1];
      end

      m_rdvalid <= '0;
      if (pipe_vld[RD_LATENCY]) begin
        m_rdvalid[pipe_idx[RD_LATENCY]] <= 1'b1;
        m_rddata[32'(pipe_idx[RD_LATENCY])*8 +: 8] <=
          s_rddata[32'(pipe_lane[RD_LATENCY])*8 +: 8];
      end
    end
  end

endmodule

// File: doc/intbus_arbiter.md
# intbus_arbiter

Parametrised internal-bus arbiter that shares one wide, byte-lane-selected RAM port between several 8-bit internal bus masters. Typical masters are the 6502 external-bus bridge and the video fetch engine. It sits between those masters and the main RAM, replacing the single-master direct hookup. It adds:
- round-robin or fixed-priority arbitration;
- registered slave-side outputs;
- a tagged read-return pipeline that matches a configurable RAM read latency.

## Interface
Parameters:
- NUM_MASTERS, default 2: number of masters, 1..4.
- ADDR_WIDTH, default 17: master byte-address width.
- LANES, default 4: bytes per RAM word; power of 2, 1..8.
- RD_LATENCY, default 1: slave read latency in cycles, from `s_strobe` cycle to `s_rddata` valid; 1..3.
- ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (master 0 highest).

Ports (clock and reset first):
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, synchronous, active-low.
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  byte address per master; master i occupies slice i.
- m_wrdata  in  NUM_MASTERS*8  write byte per master.
- m_strobe  in  NUM_MASTERS  request pending; held high until acked.
- m_write  in  NUM_MASTERS  1 = write, 0 = read.
- m_ack  out  NUM_MASTERS  request accepted this cycle; combinational, one-hot or zero.
- m_rddata  out  NUM_MASTERS*8  read byte per master.
- m_rdvalid  out  NUM_MASTERS  one-cycle pulse: `m_rddata` slice is valid.
- s_addr  out  ADDR_WIDTH-log2(LANES)  RAM word address.
- s_wrdata  out  8*LANES  write byte replicated across all lanes.
- s_wrbytesel  out  LANES  one-hot lane enable; zero for reads.
- s_write  out  1  write strobe.
- s_strobe  out  1  access issued (read or write).
- s_rddata  in  8*LANES  RAM read word.

## Operation
- Every cycle, select at most one master among those with `m_strobe` high. `m_ack[i]` is high in that same cycle.
- Round-robin (ARB_MODE=0): search starts at `last+1` mod NUM_MASTERS. `last` updates to the granted index on each grant. Reset value of `last` is NUM_MASTERS-1, so master 0 wins first.
- Fixed (ARB_MODE=1): the lowest-index requester wins. Starvation is permitted.
- On grant, register into the s_* outputs for the next cycle:
  - `s_addr` = `addr[ADDR_WIDTH-1:log2 LANES]`;
  - `s_wrdata` = `{LANES{wrdata}}`;
  - `s_wrbytesel` = one-hot of `addr[log2 LANES-1:0]` when writing, else 0;
  - `s_write` = `m_write`;
  - `s_strobe` = 1.
- No grant: `s_strobe`, `s_write` and `s_wrbytesel` are 0; `s_addr` and `s_wrdata` hold their previous values.
- Read return: on each granted read, push {valid, master index, lane} into a shift pipeline of depth RD_LATENCY+1. At its output:
  - register byte `s_rddata[8*lane +: 8]` into that master's `m_rddata` slice;
  - pulse `m_rdvalid[idx]` for one cycle.
- Reads complete strictly in issue order.
- Writes produce no `m_rdvalid`.
- `m_rddata` slices hold their last value until the next read return for that master.
- Reset (`rst_n` low at a clock edge) clears all of the following to 0:
  - `s_strobe`, `s_write`, `s_wrbytesel`, `s_addr`, `s_wrdata`;
  - all `m_rddata` and `m_rdvalid`;
  - all pipeline valid bits.
- Reset also sets `last` to NUM_MASTERS-1.
- While `rst_n` is low, `m_ack` = 0.
- Reads in flight at reset are discarded and never produce `m_rdvalid`.

## Timing
- Grant in cycle N (`m_ack` high) → `s_strobe` high in cycle N+1.
- Read data `s_rddata` is sampled in cycle N+1+RD_LATENCY.
- `m_rdvalid` and `m_rddata` are valid in cycle N+2+RD_LATENCY. With RD_LATENCY=1 this is ack+3.
- A master may change its request at the edge ending its ack cycle. If its strobe is still high after ack, that is a new request.
- Throughput is one access per cycle. Back-to-back grants to the same master are allowed when it is the only requester.
- Round-robin with all NUM_MASTERS requesting continuously: each master is granted exactly once every NUM_MASTERS cycles.
- Grants arriving while reads are in flight are accepted. The pipeline never stalls and never fills, because depth equals latency.
- Read and write to the same word in consecutive cycles: the RAM defines the ordering; the arbiter issues them in grant order.

## Test plan
- Write addressing: LANES=4, master 0 writes 0xA5 to byte address 0x00006 → next cycle `s_strobe`=1, `s_write`=1, `s_addr`=0x0001, `s_wrbytesel`=4'b0100, `s_wrdata`=0xA5A5A5A5. No `m_rdvalid`.
- Read return: RAM model (RD_LATENCY=1) holds word 0x0001=0x11A52233; master 1 reads 0x00006 → `m_rdvalid[1]` pulses at ack+3 with `m_rddata[1]`=0xA5, and `m_rdvalid[0]` stays 0.
- Round-robin fairness: NUM_MASTERS=2, both strobing for 6 cycles from reset → grant sequence 0,1,0,1,0,1. Then master 0 drops → master 1 is granted every cycle.
- Fixed priority: ARB_MODE=1, both strobing continuously → master 0 acked every cycle and master 1 never. Master 0 drops → master 1 is acked in that same cycle.
- Latency and ordering: NUM_MASTERS=3, RD_LATENCY=3; masters 0,1,2 read lanes 3,0,2 in consecutive cycles → `m_rdvalid[0]`, `m_rdvalid[1]`, `m_rdvalid[2]` pulse in consecutive cycles, each at ack+5, each with the correct lane byte.
- Reset mid-read: master 0 read acked in cycle N, `rst_n` low at the edge ending N+1 → no `m_rdvalid` ever for that read. All outputs are 0 after reset, and the first grant after reset goes to master 0.
